// File: rtl/pacman_pkg.sv
// Shared maze/sprite constants and enums for the ghost and Pac-Man sensing blocks.
package pacman_pkg;

  localparam int TILE_WIDTH  = 17;
  localparam int TILE_HEIGHT = 15;
  localparam int MAP_COLS    = 37;
  localparam int MAP_ROWS    = 32;
  localparam int SCREEN_W    = 640;
  localparam int SCREEN_H    = 480;
  localparam int SPRITE_SIZE = 16;

  // Probe order: two probes per side, just outside the sprite box.
  typedef enum logic [2:0] {
    UP_L, UP_R, DN_L, DN_R, LF_T, LF_B, RT_T, RT_B
  } probe_e;

  typedef enum logic [1:0] {
    S_IDLE, S_ISSUE, S_DRAIN, S_COMMIT
  } scan_state_e;

endpackage

// File: rtl/ghost_probe_addr.sv
// Combinational probe generator: sprite snapshot + probe index -> tile address
// and an out-of-bounds flag. Shared with the Pac-Man wall sensor.
module ghost_probe_addr #(
  parameter int TILE_WIDTH  = pacman_pkg::TILE_WIDTH,
  parameter int TILE_HEIGHT = pacman_pkg::TILE_HEIGHT,
  parameter int MAP_COLS    = pacman_pkg::MAP_COLS,
  parameter int MAP_ROWS    = pacman_pkg::MAP_ROWS,
  parameter int ADDR_W      = 11,
  parameter int SPRITE_SIZE = pacman_pkg::SPRITE_SIZE,
  parameter int SCREEN_W    = pacman_pkg::SCREEN_W,
  parameter int SCREEN_H    = pacman_pkg::SCREEN_H
) (
  input  logic [9:0]         sx,
  input  logic [9:0]         sy,
  input  pacman_pkg::probe_e probe,
  output logic [ADDR_W-1:0]  addr,
  output logic               oob
);
  import pacman_pkg::*;

  localparam logic signed [10:0] NEAR = 11'sd0;
  localparam logic signed [10:0] BACK = -11'sd1;
  localparam logic signed [10:0] FAR  = 11'(SPRITE_SIZE - 1);
  localparam logic signed [10:0] OUT  = 11'(SPRITE_SIZE);

  logic signed [10:0] dx, dy, px, py;
  int px_i, py_i, tile_x, tile_y, addr_i;

  // Offset the snapshot to the selected probe pixel, then bound-check and index.
  always_comb begin
    dx = NEAR;
    dy = NEAR;
    case (probe)
      UP_L:    begin dx = NEAR; dy = BACK; end
      UP_R:    begin dx = FAR;  dy = BACK; end
      DN_L:    begin dx = NEAR; dy = OUT;  end
      DN_R:    begin dx = FAR;  dy = OUT;  end
      LF_T:    begin dx = BACK; dy = NEAR; end
      LF_B:    begin dx = BACK; dy = FAR;  end
      RT_T:    begin dx = OUT;  dy = NEAR; end
      RT_B:    begin dx = OUT;  dy = FAR;  end
      default: begin dx = NEAR; dy = NEAR; end
    endcase
    // 11-bit signed: sx+16 past 1023 wraps negative, which is still rejected.
    px = $signed({1'b0, sx}) + dx;
    py = $signed({1'b0, sy}) + dy;
    px_i = int'(px);
    py_i = int'(py);
    tile_x = px_i / TILE_WIDTH;
    tile_y = py_i / TILE_HEIGHT;
    oob = (px_i < 0) || (py_i < 0) ||
          (px_i > SCREEN_W - 1) || (py_i > SCREEN_H - 1) ||
          (tile_x >= MAP_COLS) || (tile_y >= MAP_ROWS);
    addr_i = tile_y * MAP_COLS + tile_x;
    addr = oob ? '0 : ADDR_W'(addr_i);
  end

endmodule

// File: rtl/ghost_wall_probe.sv
// Once-per-frame ghost wall sensor: snapshots the ghost position, reads the
// eight edge probes from the map ROM and commits four blocked flags at once.
// Map port: map_addr/map_rd_en are presented for one cycle; map_wall is taken
// as the answer in the following cycle. Probes with rd_en low count as wall.
module ghost_wall_probe #(
  parameter int TILE_WIDTH  = pacman_pkg::TILE_WIDTH,
  parameter int TILE_HEIGHT = pacman_pkg::TILE_HEIGHT,
  parameter int MAP_COLS    = pacman_pkg::MAP_COLS,
  parameter int MAP_ROWS    = pacman_pkg::MAP_ROWS,
  parameter int ADDR_W      = 11,
  parameter int SPRITE_SIZE = pacman_pkg::SPRITE_SIZE
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [9:0]        ghost_x,
  input  logic [9:0]        ghost_y,
  output logic              map_rd_en,
  output logic [ADDR_W-1:0] map_addr,
  input  logic              map_wall,
  output logic              busy,
  output logic              done,
  output logic              ghost_up_wall,
  output logic              ghost_down_wall,
  output logic              ghost_left_wall,
  output logic              ghost_right_wall
);
  import pacman_pkg::*;

  scan_state_e       state;
  logic [2:0]        probe_idx;
  logic [9:0]        snap_x, snap_y;
  logic [7:0]        result;
  logic              rd_prev;
  logic              probe_bit;
  logic [9:0]        sel_x, sel_y;
  probe_e            sel_probe;
  logic [ADDR_W-1:0] next_addr;
  logic              next_oob;

  // Select the probe presented next cycle: probe 0 from live inputs on start,
  // otherwise the following probe from the snapshot.
  always_comb begin
    if (state == S_IDLE) begin
      sel_x     = ghost_x;
      sel_y     = ghost_y;
      sel_probe = UP_L;
    end else begin
      sel_x     = snap_x;
      sel_y     = snap_y;
      sel_probe = probe_e'(probe_idx + 3'd1);
    end
    probe_bit = rd_prev ? map_wall : 1'b1;
  end

  ghost_probe_addr #(
    .TILE_WIDTH (TILE_WIDTH),
    .TILE_HEIGHT(TILE_HEIGHT),
    .MAP_COLS   (MAP_COLS),
    .MAP_ROWS   (MAP_ROWS),
    .ADDR_W     (ADDR_W),
    .SPRITE_SIZE(SPRITE_SIZE),
    .SCREEN_W   (SCREEN_W),
    .SCREEN_H   (SCREEN_H)
  ) u_addr (
    .sx   (sel_x),
    .sy   (sel_y),
    .probe(sel_probe),
    .addr (next_addr),
    .oob  (next_oob)
  );

  // Scan FSM: issue 8 reads, drain the last answer, commit all flags together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= S_IDLE;
      probe_idx        <= '0;
      snap_x           <= '0;
      snap_y           <= '0;
      result           <= '0;
      rd_prev          <= 1'b0;
      map_rd_en        <= 1'b0;
      map_addr         <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      ghost_up_wall    <= 1'b1;
      ghost_down_wall  <= 1'b1;
      ghost_left_wall  <= 1'b1;
      ghost_right_wall <= 1'b1;
    end else begin
      done    <= 1'b0;
      rd_prev <= map_rd_en;
      case (state)
        S_IDLE: begin
          if (start) begin
            snap_x    <= ghost_x;
            snap_y    <= ghost_y;
            probe_idx <= '0;
            busy      <= 1'b1;
            map_rd_en <= ~next_oob;
            map_addr  <= next_addr;
            state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          // Answer for the previous probe arrives now; none yet for probe 0.
          if (probe_idx != 3'd0) result <= {probe_bit, result[7:1]};
          if (probe_idx == 3'd7) begin
            map_rd_en <= 1'b0;
            map_addr  <= '0;
            state     <= S_DRAIN;
          end else begin
            map_rd_en <= ~next_oob;
            map_addr  <= next_addr;
            probe_idx <= probe_idx + 3'd1;
          end
        end
        S_DRAIN: begin
          result <= {probe_bit, result[7:1]};
          state  <= S_COMMIT;
        end
        S_COMMIT: begin
          ghost_up_wall    <= result[0] | result[1];
          ghost_down_wall  <= result[2] | result[3];
          ghost_left_wall  <= result[4] | result[5];
          ghost_right_wall <= result[6] | result[7];
          done             <= 1'b1;
          busy             <= 1'b0;
          state            <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ghost_wall_probe.sv
// Bench for ghost_wall_probe: map ROM model, directed boundary scans and
// randomized scans checked against a pixel/tile reference model.
module tb_ghost_wall_probe;

  localparam int AW = 11;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [9:0]    ghost_x, ghost_y;
  logic          map_rd_en;
  logic [AW-1:0] map_addr;
  logic          map_wall;
  logic          busy, done;
  logic          up, down, left, right;

  bit            map_mem [0:2047];
  logic [AW:0]   exp_q[$];
  int            n_pass = 0;
  int            n_checks = 0;

  // Clock
  always #5 clk = ~clk;

  ghost_wall_probe dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .ghost_x         (ghost_x),
    .ghost_y         (ghost_y),
    .map_rd_en       (map_rd_en),
    .map_addr        (map_addr),
    .map_wall        (map_wall),
    .busy            (busy),
    .done            (done),
    .ghost_up_wall   (up),
    .ghost_down_wall (down),
    .ghost_left_wall (left),
    .ghost_right_wall(right)
  );

  // Map ROM, one cycle latency; junk when not read so unread probes can't lean on it.
  always @(posedge clk) map_wall <= map_rd_en ? map_mem[map_addr] : 1'($urandom);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  // Reference: probe pixel from the sprite box, then screen/map bounds and tile index.
  function automatic void model_probe(input int sx, input int sy, input int k,
                                      output bit oob, output int addr);
    int px, py;
    int s = 16;
    case (k)
      0: begin px = sx;         py = sy - 1;     end
      1: begin px = sx + s - 1; py = sy - 1;     end
      2: begin px = sx;         py = sy + s;     end
      3: begin px = sx + s - 1; py = sy + s;     end
      4: begin px = sx - 1;     py = sy;         end
      5: begin px = sx - 1;     py = sy + s - 1; end
      6: begin px = sx + s;     py = sy;         end
      default: begin px = sx + s; py = sy + s - 1; end
    endcase
    oob = (px < 0) || (py < 0) || (px > 639) || (py > 479) ||
          (px / 17 >= 37) || (py / 15 >= 32);
    addr = oob ? 0 : (py / 15) * 37 + px / 17;
  endfunction

  task automatic fill_map(input int density);
    for (int i = 0; i < 2048; i++) map_mem[i] = ($urandom_range(0, 99) < density);
  endtask

  // One scan; restart_at / reset_at give the edge offset from T for disturbances (-1 = none).
  task automatic run_scan(input int gx, input int gy, input int restart_at,
                          input int reset_at, input string tag);
    bit         oob;
    int         a;
    bit         r [8];
    logic [3:0] exp_flags;
    logic [AW:0] e;
    @(negedge clk);
    ghost_x = gx[9:0];
    ghost_y = gy[9:0];
    start   = 1'b1;
    for (int k = 0; k < 8; k++) begin
      model_probe(gx, gy, k, oob, a);
      r[k] = oob ? 1'b1 : map_mem[a];
      exp_q.push_back({~oob, AW'(a)});
    end
    exp_flags = {r[0] | r[1], r[2] | r[3], r[4] | r[5], r[6] | r[7]};
    @(posedge clk);
    for (int c = 0; c <= 11; c++) begin
      @(negedge clk);
      start = 1'b0;
      reset = 1'b0;
      if (reset_at >= 0 && c >= reset_at) begin
        check({tag, "_abort_done"}, 32'(done), 32'd0);
        check({tag, "_abort_busy"}, 32'(busy), 32'd0);
        check({tag, "_abort_flags"}, 32'({up, down, left, right}), 32'hF);
        check({tag, "_abort_rd"}, 32'({map_rd_en, map_addr}), 32'd0);
      end else begin
        if (c <= 7) begin
          e = exp_q.pop_front();
          check($sformatf("%s_probe%0d", tag, c), 32'({map_rd_en, map_addr}), 32'(e));
        end
        if (c <= 9) begin
          check($sformatf("%s_busy%0d", tag, c), 32'(busy), 32'd1);
          check($sformatf("%s_nodone%0d", tag, c), 32'(done), 32'd0);
        end
        if (c == 10) begin
          check({tag, "_done"}, 32'(done), 32'd1);
          check({tag, "_idle"}, 32'(busy), 32'd0);
          check({tag, "_flags"}, 32'({up, down, left, right}), 32'(exp_flags));
        end
        if (c == 11) begin
          check({tag, "_done_once"}, 32'(done), 32'd0);
          check({tag, "_flags_hold"}, 32'({up, down, left, right}), 32'(exp_flags));
        end
      end
      if (c + 1 == restart_at) begin
        start   = 1'b1;
        ghost_x = 10'd300;
      end
      if (c + 1 == reset_at) reset = 1'b1;
    end
    exp_q.delete();
  endtask

  initial begin
    int gx, gy;
    reset   = 1'b1;
    start   = 1'b0;
    ghost_x = '0;
    ghost_y = '0;
    fill_map(0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_flags", 32'({up, down, left, right}), 32'hF);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_rd", 32'({map_rd_en, map_addr}), 32'd0);
    reset = 1'b0;

    // Directed scans
    run_scan(225, 222, -1, -1, "zero_map");
    map_mem[532] = 1'b1;
    run_scan(225, 222, -1, -1, "tile532");
    fill_map(0);
    run_scan(0, 100, -1, -1, "left_edge");
    run_scan(613, 100, -1, -1, "right_edge");
    run_scan(623, 100, -1, -1, "right_far");
    run_scan(100, 0, -1, -1, "top_edge");
    run_scan(100, 464, -1, -1, "bottom_edge");
    run_scan(1023, 1023, -1, -1, "max_pos");

    // Mid-scan start with a moved ghost is ignored
    fill_map(30);
    run_scan(225, 222, 3, -1, "restart");

    // Reset mid-scan aborts, then a fresh scan completes
    run_scan(225, 222, -1, 5, "reset_mid");
    run_scan(225, 222, -1, -1, "after_reset");

    // Randomized scans
    for (int i = 0; i < 24; i++) begin
      fill_map(30);
      if ($urandom_range(0, 3) == 0) begin
        gx = $urandom_range(0, 1023);
        gy = $urandom_range(0, 1023);
      end else begin
        gx = $urandom_range(0, 640);
        gy = $urandom_range(0, 480);
      end
      run_scan(gx, gy, -1, -1, $sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
